// File: rtl/simplecpu_uart_loader.sv
// Serial program loader for simplecpu: 8N1 receiver plus frame loader.
// Holds the CPU in reset while writing 16 bytes, releases on good checksum.
module simplecpu_uart_loader #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic       load_ram,
  output logic [3:0] load_addr,
  output logic [7:0] load_data,
  output logic       cpu_reset_n,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int CW =
    (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LP_FULL =
    CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] LP_HALF =
    CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_STOP
  } rstate_t;

  typedef enum logic [2:0] {
    L_WAIT_SYNC,
    L_LOAD,
    L_CHECK,
    L_RUN,
    L_ERROR
  } lstate_t;

  logic          r_rx_meta;
  logic          r_rx_sync;

  rstate_t       r_rstate;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bitn;
  logic [7:0]    r_shift;
  logic [7:0]    r_byte;
  logic          r_byte_valid;
  logic          r_frame_err;

  lstate_t       r_lstate;
  logic [3:0]    r_idx;
  logic [7:0]    r_sum;
  logic          r_load_ram;
  logic [3:0]    r_load_addr;
  logic [7:0]    r_load_data;
  logic          r_cpu_reset_n;
  logic          r_busy;
  logic          r_done;
  logic          r_error;

  logic [7:0]    w_sum_next;

  assign w_sum_next = r_sum + r_byte;

  // Two-flop synchroniser; idle line is high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx_in;
      r_rx_sync <= r_rx_meta;
    end
  end

  // 8N1 receiver: mid-bit sampling, single-cycle byte/framing pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rstate     <= R_IDLE;
      r_cnt        <= '0;
      r_bitn       <= '0;
      r_shift      <= '0;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      unique case (r_rstate)
        R_IDLE: begin
          r_cnt <= '0;
          if (!r_rx_sync) begin
            r_rstate <= R_START;
          end
        end
        R_START: begin
          if (r_cnt == LP_HALF) begin
            r_cnt  <= '0;
            r_bitn <= '0;
            if (r_rx_sync) begin
              r_rstate <= R_IDLE;
            end else begin
              r_rstate <= R_DATA;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (r_cnt == LP_FULL) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_sync, r_shift[7:1]};
            if (r_bitn == 3'd7) begin
              r_rstate <= R_STOP;
            end else begin
              r_bitn <= r_bitn + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (r_cnt == LP_FULL) begin
            r_cnt    <= '0;
            r_rstate <= R_IDLE;
            if (r_rx_sync) begin
              r_byte       <= r_shift;
              r_byte_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // Loader FSM with registered RAM strobe and CPU reset control.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lstate      <= L_WAIT_SYNC;
      r_idx         <= '0;
      r_sum         <= '0;
      r_load_ram    <= 1'b0;
      r_load_addr   <= '0;
      r_load_data   <= '0;
      r_cpu_reset_n <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_load_ram <= 1'b0;
      unique case (r_lstate)
        L_WAIT_SYNC, L_ERROR, L_RUN: begin
          if (r_byte_valid && r_byte == SYNC_BYTE) begin
            r_lstate      <= L_LOAD;
            r_idx         <= '0;
            r_sum         <= '0;
            r_busy        <= 1'b1;
            r_error       <= 1'b0;
            r_done        <= 1'b0;
            r_cpu_reset_n <= 1'b0;
          end
        end
        L_LOAD: begin
          if (r_frame_err) begin
            r_lstate <= L_ERROR;
            r_error  <= 1'b1;
            r_busy   <= 1'b0;
          end else if (r_byte_valid) begin
            r_load_ram  <= 1'b1;
            r_load_addr <= r_idx;
            r_load_data <= r_byte;
            r_sum       <= w_sum_next;
            if (r_idx == 4'hF) begin
              r_lstate <= L_CHECK;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        L_CHECK: begin
          if (r_frame_err) begin
            r_lstate <= L_ERROR;
            r_error  <= 1'b1;
            r_busy   <= 1'b0;
          end else if (r_byte_valid) begin
            r_busy <= 1'b0;
            if (w_sum_next == 8'h00) begin
              r_lstate      <= L_RUN;
              r_cpu_reset_n <= 1'b1;
              r_done        <= 1'b1;
            end else begin
              r_lstate <= L_ERROR;
              r_error  <= 1'b1;
            end
          end
        end
        default: r_lstate <= L_WAIT_SYNC;
      endcase
    end
  end

  assign load_ram    = r_load_ram;
  assign load_addr   = r_load_addr;
  assign load_data   = r_load_data;
  assign cpu_reset_n = r_cpu_reset_n;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;

endmodule

// File: doc/simplecpu_uart_loader.md
Name: simplecpu_uart_loader

Overview:
- Serial program loader that drives the simplecpu RAM load bus (load_ram/load_addr/load_data) and the CPU reset.
- Receives an 8N1 UART frame: SYNC byte, 16 program bytes, checksum byte. Writes bytes 0..15 into CPU RAM while holding the CPU in reset.
- Releases the CPU only after a valid checksum. Sits between the chip pad rx input and simplecpu.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; must be ≥4 and even.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- rx_in  input  1  asynchronous UART line, idle high.
- load_ram  output  1  one-cycle write strobe to the CPU RAM.
- load_addr  output  4  RAM address for the strobe.
- load_data  output  8  RAM data for the strobe.
- cpu_reset_n  output  1  CPU reset: 0 holds the CPU in reset, 1 runs it. Drives simplecpu.reset.
- busy  output  1  frame reception in progress.
- done  output  1  valid program loaded; CPU running.
- error  output  1  last frame failed (checksum or framing).

Behaviour:
- Reset: while reset=0 at a clk edge, all state is cleared.
  - Outputs: load_ram=0, load_addr=0, load_data=0, cpu_reset_n=0, busy=0, done=0, error=0.
  - Receiver returns to idle; loader FSM goes to WAIT_SYNC. Reset mid-frame abandons the frame; no further strobes are issued.
- RX synchroniser: 2-flop on rx_in. All receiver logic uses the synced value (2-cycle input latency).
- Receiver FSM: R_IDLE → R_START → R_DATA → R_STOP.
  - R_IDLE: synced rx=0 → R_START, counter cleared.
  - R_START: after CLKS_PER_BIT/2 cycles, resample. rx=1 is a false start → R_IDLE. rx=0 → R_DATA.
  - R_DATA: sample every CLKS_PER_BIT cycles; 8 bits, LSB first, into a shift register.
  - R_STOP: sample once after CLKS_PER_BIT cycles. rx=1 raises byte_valid for 1 cycle. rx=0 raises frame_err for 1 cycle. Either way → R_IDLE.
- Loader FSM: WAIT_SYNC, LOAD, CHECK, RUN, ERROR. idx is a 4-bit counter; sum is an 8-bit accumulator.
  - WAIT_SYNC:
    - byte==SYNC_BYTE → LOAD, with idx=0, sum=0, busy=1, error=0, done=0, cpu_reset_n=0.
    - Other bytes and frame_err are ignored.
  - LOAD, on each byte_valid:
    - Next cycle: load_ram=1, load_addr=idx, load_data=byte. Strobe is exactly 1 cycle; addr/data hold until the next strobe.
    - sum += byte (mod 256).
    - idx==15 → CHECK; otherwise idx+1.
  - CHECK: the next byte is the checksum (not written to RAM).
    - (sum+byte) mod 256 == 0 → RUN: cpu_reset_n=1, done=1, busy=0.
    - Otherwise → ERROR.
  - frame_err in LOAD or CHECK → ERROR.
  - ERROR: error=1, busy=0, cpu_reset_n=0, done=0.
    - SYNC_BYTE → LOAD (error cleared as above).
    - Other bytes are ignored.
  - RUN:
    - SYNC_BYTE → cpu_reset_n=0 the cycle after byte_valid, then LOAD (reload path).
    - Other bytes and frame_err are ignored; CPU keeps running.
- cpu_reset_n is 0 on every cycle where load_ram=1. This is required: the CPU accepts load writes only while held in reset.
- Only byte_valid and frame_err advance the loader, so no simultaneous events are possible.
- SYNC_BYTE appearing as data or checksum is treated as data.
- idx never wraps: the 17th byte after SYNC is always the checksum.

Test Plan (CLKS_PER_BIT=4):
- Good load: send A5, bytes 8'h10..8'h1F, checksum 8'h88.
  - 16 strobes, addr 0..15, data 10..1F.
  - One cycle after the checksum stop sample: cpu_reset_n=1, done=1, busy=0, error=0.
- Bad checksum: same frame with checksum 8'h89 → error=1, cpu_reset_n stays 0, done=0.
  - Then a full good frame → done=1, error=0.
- Noise before sync: send 00, FF, 5A, then a good frame → no strobes before A5; load completes normally.
- False start and framing error:
  - 1-cycle low glitch on rx (shorter than CLKS_PER_BIT/2) → no byte, state unchanged.
  - In LOAD after 3 bytes, send a byte with stop bit 0 → ERROR, no 4th strobe.
- Reload from RUN: after a good load, send A5 → cpu_reset_n falls; a new 18-byte frame rewrites RAM; cpu_reset_n returns to 1.
- Reset mid-frame: assert reset=0 after 5 data bytes → all outputs 0 next edge.
  - After release, remaining bytes are ignored until a new A5.
